// File: rtl/tl_slave_mem_beh.sv
// Behavioral TileLink slave memory (Get/PutFull/PutPartial, bursts to 64B); B/C/E tied off. Option: TL_SLAVE_BACKPRESSURE_EN.
// Latency: D valid one cycle after the (last) A beat fires; Get bursts stream back-to-back while d_ready.
// Backpressure: a_ready low while a response is pending; optional LFSR stalls of a_ready; D held while !d_ready.
module tl_slave_mem_beh #(
  parameter int SRC_SIZE  = 2,
  parameter int SINK_SIZE = 3,
  parameter int BUS_SIZE  = 8,
  parameter int ADR_WIDTH = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic                    clock,
  input  logic                    reset_n,
  output logic                    a_ready,
  input  logic                    a_valid,
  input  logic [2:0]              a_bits_opcode,
  input  logic [2:0]              a_bits_param,
  input  logic [3:0]              a_bits_size,
  input  logic [SRC_SIZE-1:0]     a_bits_source,
  input  logic [ADR_WIDTH-1:0]    a_bits_address,
  input  logic [BUS_SIZE-1:0]     a_bits_mask,
  input  logic [8*BUS_SIZE-1:0]   a_bits_data,
  input  logic                    a_bits_corrupt,
  input  logic                    b_ready,
  output logic                    b_valid,
  output logic [2:0]              b_bits_opcode,
  output logic [1:0]              b_bits_param,
  output logic [3:0]              b_bits_size,
  output logic [SRC_SIZE-1:0]     b_bits_source,
  output logic [ADR_WIDTH-1:0]    b_bits_address,
  output logic [BUS_SIZE-1:0]     b_bits_mask,
  output logic [8*BUS_SIZE-1:0]   b_bits_data,
  output logic                    b_bits_corrupt,
  output logic                    c_ready,
  input  logic                    c_valid,
  input  logic [2:0]              c_bits_opcode,
  input  logic [2:0]              c_bits_param,
  input  logic [3:0]              c_bits_size,
  input  logic [SRC_SIZE-1:0]     c_bits_source,
  input  logic [ADR_WIDTH-1:0]    c_bits_address,
  input  logic [8*BUS_SIZE-1:0]   c_bits_data,
  input  logic                    c_bits_corrupt,
  input  logic                    d_ready,
  output logic                    d_valid,
  output logic [2:0]              d_bits_opcode,
  output logic [1:0]              d_bits_param,
  output logic [3:0]              d_bits_size,
  output logic [SRC_SIZE-1:0]     d_bits_source,
  output logic [SINK_SIZE-1:0]    d_bits_sink,
  output logic                    d_bits_denied,
  output logic [8*BUS_SIZE-1:0]   d_bits_data,
  output logic                    d_bits_corrupt,
  output logic                    e_ready,
  input  logic                    e_valid,
  input  logic [SINK_SIZE-1:0]    e_bits_sink
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  typedef enum logic [1:0] {IDLE, PUT_DATA, GET_RESP, PUT_RESP} state_t;

  typedef struct packed {
    logic [3:0]          size;
    logic [SRC_SIZE-1:0] source;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          beats;
    logic                denied;
  } req_t;

  state_t state, nxt_state;
  req_t   req, nxt_req;
  logic [3:0] beat, nxt_beat;

  logic [8*BUS_SIZE-1:0] mem [MEM_WORDS];

  logic             st_rdy, bp_ok, a_fire, d_fire, bad_req;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx, a_idx, cur_idx;
  logic [BUS_SIZE-1:0] wr_mask;

  function automatic logic [3:0] beats_of(input logic [3:0] sz);
    beats_of = (sz <= 4'd3) ? 4'd1 : (4'd1 << (sz - 4'd3));
  endfunction

`ifdef TL_SLAVE_BACKPRESSURE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr <= 16'hACE1;
    else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign bp_ok = (lfsr[1:0] != 2'b00);
`else
  assign bp_ok = 1'b1;
`endif

  assign st_rdy  = (state == IDLE) || (state == PUT_DATA);
  // Gate with reset so the master sees a_ready low for the whole reset window.
  assign a_ready = reset_n & st_rdy & bp_ok;
  assign d_valid = (state == GET_RESP) || (state == PUT_RESP);
  assign a_fire  = a_valid & a_ready;
  assign d_fire  = d_valid & d_ready;
  assign a_idx   = a_bits_address[3 +: IDX_W];
  assign cur_idx = req.idx + IDX_W'(beat);
  assign bad_req = !((a_bits_opcode == OP_PUT_FULL) || (a_bits_opcode == OP_PUT_PART) ||
                     (a_bits_opcode == OP_GET)) || (a_bits_size > 4'd6);
  assign wr_mask = (a_bits_opcode == OP_PUT_FULL) ? '1 : a_bits_mask;

  always_comb begin
    nxt_state      = state;
    nxt_req        = req;
    nxt_beat       = beat;
    wr_en          = 1'b0;
    wr_idx         = cur_idx;
    d_bits_opcode  = '0;
    d_bits_param   = '0;
    d_bits_size    = '0;
    d_bits_source  = '0;
    d_bits_sink    = '0;
    d_bits_denied  = 1'b0;
    d_bits_data    = '0;
    d_bits_corrupt = 1'b0;
    case (state)
      IDLE: begin
        wr_idx = a_idx;
        if (a_fire) begin
          nxt_req.size   = a_bits_size;
          nxt_req.source = a_bits_source;
          nxt_req.idx    = a_idx;
          nxt_req.beats  = beats_of(a_bits_size);
          nxt_req.denied = bad_req;
          nxt_beat       = '0;
          if (bad_req) begin
            nxt_state = PUT_RESP;
          end else if (a_bits_opcode == OP_GET) begin
            nxt_state = GET_RESP;
          end else begin
            wr_en = !a_bits_corrupt;
            if (beats_of(a_bits_size) == 4'd1) begin
              nxt_state = PUT_RESP;
            end else begin
              nxt_beat  = 4'd1;
              nxt_state = PUT_DATA;
            end
          end
        end
      end
      PUT_DATA: begin
        if (a_fire) begin
          wr_en = !a_bits_corrupt;
          if (beat + 4'd1 == req.beats) begin
            nxt_beat  = '0;
            nxt_state = PUT_RESP;
          end else begin
            nxt_beat = beat + 4'd1;
          end
        end
      end
      GET_RESP: begin
        d_bits_opcode = 3'd1;
        d_bits_size   = req.size;
        d_bits_source = req.source;
        d_bits_data   = mem[cur_idx];
        if (d_fire) begin
          if (beat + 4'd1 == req.beats) begin
            nxt_beat  = '0;
            nxt_state = IDLE;
          end else begin
            nxt_beat = beat + 4'd1;
          end
        end
      end
      PUT_RESP: begin
        d_bits_opcode = 3'd0;
        d_bits_size   = req.size;
        d_bits_source = req.source;
        d_bits_denied = req.denied;
        if (d_fire) nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      req   <= '0;
      beat  <= '0;
    end else begin
      state <= nxt_state;
      req   <= nxt_req;
      beat  <= nxt_beat;
    end
  end

  // Backing store is deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < BUS_SIZE; i++) begin
        if (wr_mask[i]) mem[wr_idx][8*i +: 8] <= a_bits_data[8*i +: 8];
      end
    end
  end

  assign b_valid        = 1'b0;
  assign b_bits_opcode  = '0;
  assign b_bits_param   = '0;
  assign b_bits_size    = '0;
  assign b_bits_source  = '0;
  assign b_bits_address = '0;
  assign b_bits_mask    = '0;
  assign b_bits_data    = '0;
  assign b_bits_corrupt = 1'b0;
  assign c_ready        = 1'b1;
  assign e_ready        = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{a_bits_param, a_bits_address, b_ready, c_valid, c_bits_opcode,
                           c_bits_param, c_bits_size, c_bits_source, c_bits_address,
                           c_bits_data, c_bits_corrupt, e_valid, e_bits_sink};

endmodule

// File: tb/tb_tl_slave_mem_beh.sv
// Directed bench for tl_slave_mem_beh: put/get, partial writes, bursts, wrap, denied requests, reset mid-burst.
module tb_tl_slave_mem_beh;

  localparam logic [2:0] OP_PUTF = 3'd0;
  localparam logic [2:0] OP_PUTP = 3'd1;
  localparam logic [2:0] OP_GET  = 3'd4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_ready, a_valid = 1'b0;
  logic [2:0]  a_bits_opcode = '0, a_bits_param = '0;
  logic [3:0]  a_bits_size = '0;
  logic [1:0]  a_bits_source = '0;
  logic [31:0] a_bits_address = '0;
  logic [7:0]  a_bits_mask = '0;
  logic [63:0] a_bits_data = '0;
  logic        a_bits_corrupt = 1'b0;
  logic        b_valid, b_bits_corrupt;
  logic [2:0]  b_bits_opcode;
  logic [1:0]  b_bits_param;
  logic [3:0]  b_bits_size;
  logic [1:0]  b_bits_source;
  logic [31:0] b_bits_address;
  logic [7:0]  b_bits_mask;
  logic [63:0] b_bits_data;
  logic        c_ready;
  logic        d_ready = 1'b0, d_valid;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_param;
  logic [3:0]  d_bits_size;
  logic [1:0]  d_bits_source;
  logic [2:0]  d_bits_sink;
  logic        d_bits_denied, d_bits_corrupt;
  logic [63:0] d_bits_data;
  logic        e_ready;

  int checks = 0;
  int failures = 0;
  int bp_stalls = 0;

  always #5 clock = ~clock;

  tl_slave_mem_beh dut (
    .clock(clock), .reset_n(reset_n),
    .a_ready(a_ready), .a_valid(a_valid), .a_bits_opcode(a_bits_opcode), .a_bits_param(a_bits_param),
    .a_bits_size(a_bits_size), .a_bits_source(a_bits_source), .a_bits_address(a_bits_address),
    .a_bits_mask(a_bits_mask), .a_bits_data(a_bits_data), .a_bits_corrupt(a_bits_corrupt),
    .b_ready(1'b1), .b_valid(b_valid), .b_bits_opcode(b_bits_opcode), .b_bits_param(b_bits_param),
    .b_bits_size(b_bits_size), .b_bits_source(b_bits_source), .b_bits_address(b_bits_address),
    .b_bits_mask(b_bits_mask), .b_bits_data(b_bits_data), .b_bits_corrupt(b_bits_corrupt),
    .c_ready(c_ready), .c_valid(1'b0), .c_bits_opcode(3'd0), .c_bits_param(3'd0), .c_bits_size(4'd0),
    .c_bits_source(2'd0), .c_bits_address(32'd0), .c_bits_data(64'd0), .c_bits_corrupt(1'b0),
    .d_ready(d_ready), .d_valid(d_valid), .d_bits_opcode(d_bits_opcode), .d_bits_param(d_bits_param),
    .d_bits_size(d_bits_size), .d_bits_source(d_bits_source), .d_bits_sink(d_bits_sink),
    .d_bits_denied(d_bits_denied), .d_bits_data(d_bits_data), .d_bits_corrupt(d_bits_corrupt),
    .e_ready(e_ready), .e_valid(1'b0), .e_bits_sink(3'd0)
  );

  // Presents one A beat and returns #1 after the edge on which it fired.
  task automatic a_send(input logic [2:0] op, input logic [3:0] sz, input logic [1:0] src,
                        input logic [31:0] adr, input logic [7:0] msk, input logic [63:0] dat,
                        input logic cor);
    bit got = 0;
    a_valid = 1'b1; a_bits_opcode = op; a_bits_size = sz; a_bits_source = src;
    a_bits_address = adr; a_bits_mask = msk; a_bits_data = dat; a_bits_corrupt = cor;
    for (int i = 0; i < 60 && !got; i++) begin
      if (a_ready === 1'b1) got = 1;
      else bp_stalls++;
      @(posedge clock); #1;
    end
    a_valid = 1'b0; a_bits_corrupt = 1'b0;
    checks++;
    if (!got) begin failures++; $display("FAIL a_accept op=%0d adr=%h never accepted", op, adr); end
  endtask

  task automatic d_wait();
    for (int i = 0; i < 60 && d_valid !== 1'b1; i++) begin @(posedge clock); #1; end
    checks++;
    if (d_valid !== 1'b1) begin failures++; $display("FAIL d_timeout d_valid=%b required 1", d_valid); end
  endtask

  task automatic d_take();
    d_ready = 1'b1; @(posedge clock); #1; d_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL rst_a_ready got=%b exp=0", a_ready); end
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL rst_d_valid got=%b exp=0", d_valid); end
    checks++; if (d_bits_data !== 64'd0) begin failures++; $display("FAIL rst_d_data got=%h exp=0", d_bits_data); end
    checks++; if ({d_bits_opcode, d_bits_size, d_bits_source, d_bits_denied} !== 10'd0) begin
      failures++; $display("FAIL rst_d_bits got op=%0d sz=%0d src=%0d den=%b exp all 0",
                           d_bits_opcode, d_bits_size, d_bits_source, d_bits_denied); end
    checks++; if ({b_valid, c_ready, e_ready} !== 3'b011) begin
      failures++; $display("FAIL tieoffs got b_valid=%b c_ready=%b e_ready=%b exp 0/1/1", b_valid, c_ready, e_ready); end
    reset_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL post_rst_a_ready got=%b exp=1", a_ready); end
    @(posedge clock); #1;
  endtask

  task automatic test_put_get();
    a_send(OP_PUTF, 4'd3, 2'd1, 32'h80, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0);
    checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL put_latency d_valid=%b exp=1", d_valid); end
    checks++; if (d_bits_opcode !== 3'd0 || d_bits_source !== 2'd1 || d_bits_denied !== 1'b0) begin
      failures++; $display("FAIL put_ack got op=%0d src=%0d den=%b exp 0/1/0", d_bits_opcode, d_bits_source, d_bits_denied); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL put_pending_a_ready got=%b exp=0", a_ready); end
    d_take();
    a_send(OP_GET, 4'd3, 2'd2, 32'h80, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL get_latency d_valid=%b exp=1", d_valid); end
    checks++; if (d_bits_opcode !== 3'd1 || d_bits_size !== 4'd3 || d_bits_source !== 2'd2) begin
      failures++; $display("FAIL get_hdr got op=%0d sz=%0d src=%0d exp 1/3/2", d_bits_opcode, d_bits_size, d_bits_source); end
    checks++; if (d_bits_data !== 64'h0123_4567_89AB_CDEF) begin
      failures++; $display("FAIL get_data got=%h exp=0123456789abcdef", d_bits_data); end
    d_take();
  endtask

  task automatic test_partial();
    a_send(OP_PUTF, 4'd3, 2'd0, 32'h10, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0); d_take();
    a_send(OP_PUTP, 4'd3, 2'd0, 32'h10, 8'h0F, 64'd0, 1'b0); d_take();
    a_send(OP_GET, 4'd3, 2'd0, 32'h10, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_bits_data !== 64'hFFFF_FFFF_0000_0000) begin
      failures++; $display("FAIL partial_data got=%h exp=ffffffff00000000", d_bits_data); end
    d_take();
    a_send(OP_PUTF, 4'd3, 2'd0, 32'h10, 8'hFF, 64'd0, 1'b1); d_take();
    a_send(OP_GET, 4'd3, 2'd0, 32'h10, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_bits_data !== 64'hFFFF_FFFF_0000_0000) begin
      failures++; $display("FAIL corrupt_suppress got=%h exp=ffffffff00000000", d_bits_data); end
    d_take();
  endtask

  task automatic test_burst();
    int b = 0;
    for (int i = 0; i < 8; i++) begin
      a_send(OP_PUTF, 4'd6, 2'd3, 32'h100, 8'h00, 64'(i), 1'b0);
      if (i < 7) begin
        checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL burst_early_ack beat=%0d d_valid=%b exp=0", i, d_valid); end
      end
    end
    checks++; if (d_valid !== 1'b1 || d_bits_opcode !== 3'd0) begin
      failures++; $display("FAIL burst_ack got v=%b op=%0d exp 1/0", d_valid, d_bits_opcode); end
    d_take();
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL burst_single_ack d_valid=%b exp=0", d_valid); end
    a_send(OP_GET, 4'd6, 2'd1, 32'h100, 8'hFF, 64'd0, 1'b0);
    for (int cyc = 0; cyc < 40 && b < 8; cyc++) begin
      d_ready = cyc[0];
      checks++;
      if (d_valid !== 1'b1 || d_bits_data !== 64'(b) || d_bits_size !== 4'd6) begin
        failures++; $display("FAIL burst_get cyc=%0d got v=%b data=%h sz=%0d exp 1/%0d/6", cyc, d_valid, d_bits_data, d_bits_size, b);
      end
      if (d_ready) b++;
      @(posedge clock); #1;
    end
    d_ready = 1'b0;
    checks++; if (b != 8 || d_valid !== 1'b0) begin failures++; $display("FAIL burst_get_end beats=%0d v=%b exp 8/0", b, d_valid); end
  endtask

  task automatic test_wrap();
    a_send(OP_PUTF, 4'd4, 2'd0, 32'h7F8, 8'h00, 64'hAAAA_0000_0000_0001, 1'b0);
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL wrap_early_ack d_valid=%b exp=0", d_valid); end
    a_send(OP_PUTF, 4'd4, 2'd0, 32'h7F8, 8'h00, 64'hBBBB_0000_0000_0002, 1'b0);
    checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL wrap_ack d_valid=%b exp=1", d_valid); end
    d_take();
    a_send(OP_GET, 4'd3, 2'd0, 32'h1000_0000, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_bits_data !== 64'hBBBB_0000_0000_0002) begin
      failures++; $display("FAIL wrap_word0 got=%h exp=bbbb000000000002", d_bits_data); end
    d_take();
    a_send(OP_GET, 4'd4, 2'd0, 32'h7F8, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_bits_data !== 64'hAAAA_0000_0000_0001) begin
      failures++; $display("FAIL wrap_get_b0 got=%h exp=aaaa000000000001", d_bits_data); end
    d_take();
    checks++; if (d_valid !== 1'b1 || d_bits_data !== 64'hBBBB_0000_0000_0002) begin
      failures++; $display("FAIL wrap_get_b1 got v=%b data=%h exp 1/bbbb000000000002", d_valid, d_bits_data); end
    d_take();
  endtask

  task automatic test_error();
    a_send(OP_PUTF, 4'd3, 2'd0, 32'h200, 8'hFF, 64'h5555_AAAA_5555_AAAA, 1'b0); d_take();
    a_send(3'd2, 4'd6, 2'd3, 32'h200, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_valid !== 1'b1 || d_bits_opcode !== 3'd0 || d_bits_denied !== 1'b1 || d_bits_source !== 2'd3) begin
      failures++; $display("FAIL bad_op_ack got v=%b op=%0d den=%b src=%0d exp 1/0/1/3", d_valid, d_bits_opcode, d_bits_denied, d_bits_source); end
    d_take();
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL bad_op_single d_valid=%b exp=0", d_valid); end
    a_send(OP_GET, 4'd7, 2'd0, 32'h200, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_bits_opcode !== 3'd0 || d_bits_denied !== 1'b1) begin
      failures++; $display("FAIL bad_size_ack got op=%0d den=%b exp 0/1", d_bits_opcode, d_bits_denied); end
    d_take();
    a_send(OP_GET, 4'd3, 2'd0, 32'h200, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_bits_data !== 64'h5555_AAAA_5555_AAAA || d_bits_denied !== 1'b0) begin
      failures++; $display("FAIL bad_op_mem got=%h den=%b exp 5555aaaa5555aaaa/0", d_bits_data, d_bits_denied); end
    d_take();
  endtask

  task automatic test_reset_mid_burst();
    a_send(OP_GET, 4'd6, 2'd1, 32'h100, 8'hFF, 64'd0, 1'b0);
    d_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (d_valid !== 1'b1 || d_bits_data !== 64'(i)) begin
        failures++; $display("FAIL mid_beat%0d got v=%b data=%h exp 1/%0d", i, d_valid, d_bits_data, i); end
      if (i < 2) begin @(posedge clock); #1; end
    end
    reset_n = 1'b0;
    #1;
    checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL async_rst_d_valid got=%b exp=0", d_valid); end
    checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL async_rst_a_ready got=%b exp=0", a_ready); end
    d_ready = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1 || d_valid !== 1'b0) begin
      failures++; $display("FAIL rst_release got a_ready=%b d_valid=%b exp 1/0", a_ready, d_valid); end
    a_send(OP_GET, 4'd3, 2'd2, 32'h80, 8'hFF, 64'd0, 1'b0);
    checks++; if (d_valid !== 1'b1 || d_bits_data !== 64'h0123_4567_89AB_CDEF || d_bits_source !== 2'd2) begin
      failures++; $display("FAIL post_rst_get got v=%b data=%h src=%0d exp 1/0123456789abcdef/2", d_valid, d_bits_data, d_bits_source); end
    d_take();
  endtask

`ifdef TL_SLAVE_BACKPRESSURE_EN
  task automatic test_backpressure();
    logic [63:0] model [16];
    logic [63:0] dat;
    int idx;
    bp_stalls = 0;
    for (int i = 0; i < 16; i++) begin
      dat = {$urandom, $urandom}; model[i] = dat;
      a_send(OP_PUTF, 4'd3, 2'd0, 32'(i * 8), 8'hFF, dat, 1'b0); d_wait(); d_take();
    end
    for (int n = 0; n < 1000; n++) begin
      idx = $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) begin
        dat = {$urandom, $urandom}; model[idx] = dat;
        a_send(OP_PUTF, 4'd3, 2'd1, 32'(idx * 8), 8'hFF, dat, 1'b0); d_wait();
        checks++; if (d_bits_opcode !== 3'd0) begin failures++; $display("FAIL bp_put n=%0d op=%0d exp=0", n, d_bits_opcode); end
      end else begin
        a_send(OP_GET, 4'd3, 2'd2, 32'(idx * 8), 8'hFF, 64'd0, 1'b0); d_wait();
        checks++; if (d_bits_data !== model[idx]) begin
          failures++; $display("FAIL bp_get n=%0d idx=%0d got=%h exp=%h", n, idx, d_bits_data, model[idx]); end
      end
      d_take();
    end
    checks++; if (bp_stalls == 0) begin failures++; $display("FAIL bp_stall_seen count=%0d required >0", bp_stalls); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_put_get();
    test_partial();
    test_burst();
    test_wrap();
    test_error();
    test_reset_mid_burst();
`ifdef TL_SLAVE_BACKPRESSURE_EN
    test_backpressure();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
